// File: rtl/watchdog_pkg.sv
// Shared FSM state encodings and helpers for the windowed watchdog.
package watchdog_pkg;

   typedef logic [1:0] wd_state_t;

   localparam wd_state_t IDLE    = 2'h0;
   localparam wd_state_t LOAD    = 2'h1;
   localparam wd_state_t COUNT   = 2'h2;
   localparam wd_state_t TIMEOUT = 2'h3;

   function automatic logic is_running(input wd_state_t s);
      return (s == LOAD) || (s == COUNT);
   endfunction

endpackage

// File: rtl/watchdog_prescaler.sv
// Free-running tick divider: one tick every prescale+1 enabled cycles.
module watchdog_prescaler #(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      enable,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   localparam logic [PRESCALE_WIDTH-1:0] COUNT_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

   logic [PRESCALE_WIDTH-1:0] count;

   assign tick = enable && (count == prescale);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + COUNT_ONE;
      end
   end

endmodule

// File: rtl/watchdog_window.sv
// Windowed watchdog timer: IDLE/LOAD/COUNT/TIMEOUT FSM with prescaled countdown.
// Define WATCHDOG_WINDOW_EN to make kicks above window_init an early-kick timeout.
module watchdog_window #(
   parameter int TIMER_WIDTH    = 32,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [TIMER_WIDTH-1:0]    timer_init,
   input  logic [TIMER_WIDTH-1:0]    window_init,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      kick,
   output logic [TIMER_WIDTH-1:0]    curr_timer,
   output logic                      running,
   output logic                      timeout,
   output logic                      early_kick
);

   import watchdog_pkg::*;

   localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

   wd_state_t                 state;
   wd_state_t                 state_next;
   logic [TIMER_WIDTH-1:0]    timer;
   logic [TIMER_WIDTH-1:0]    timer_next;
   logic [PRESCALE_WIDTH-1:0] prescale_q;
   logic                      tick;
   logic                      sample_cfg;

   // Configuration is only observed at LOAD and on ticks, so mid-period edits wait their turn.
   assign sample_cfg = (state == LOAD) || tick;

   watchdog_prescaler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_prescaler (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == LOAD),
      .enable  (state == COUNT),
      .prescale(prescale_q),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale_q <= '0;
      end else if (sample_cfg) begin
         prescale_q <= prescale;
      end
   end

`ifdef WATCHDOG_WINDOW_EN
   logic [TIMER_WIDTH-1:0] window_q;
   logic                   kick_legal;
   logic                   early_set;
   logic                   early_kick_q;

   assign kick_legal = (timer <= window_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         window_q     <= '0;
         early_kick_q <= 1'b0;
      end else begin
         if (sample_cfg) begin
            window_q <= window_init;
         end
         if (early_set) begin
            early_kick_q <= 1'b1;
         end
      end
   end

   assign early_kick = early_kick_q;
`else
   logic window_unused;

   assign window_unused = ^window_init;
   assign early_kick    = 1'b0;
`endif

   // Within COUNT the priority is stop, then start, then kick, then tick/expiry.
   always_comb begin
      state_next = state;
      timer_next = timer;
`ifdef WATCHDOG_WINDOW_EN
      early_set  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            timer_next = timer_init;
            state_next = COUNT;
         end
         COUNT: begin
            if (stop) begin
               state_next = IDLE;
            end else if (start) begin
               state_next = LOAD;
            end else if (kick) begin
`ifdef WATCHDOG_WINDOW_EN
               if (kick_legal) begin
                  state_next = LOAD;
               end else begin
                  state_next = TIMEOUT;
                  early_set  = 1'b1;
               end
`else
               state_next = LOAD;
`endif
            end else if (tick) begin
               if (timer == '0) begin
                  state_next = TIMEOUT;
               end else begin
                  timer_next = timer - TIMER_ONE;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   assign curr_timer = timer;
   assign running    = is_running(state);
   assign timeout    = (state == TIMEOUT);

endmodule

// File: tb/tb_watchdog_window.sv
// Directed scoreboard bench for watchdog_window; windowed steps follow WATCHDOG_WINDOW_EN.
module tb_watchdog_window;

   logic        clk;
   logic        reset;
   logic [31:0] timer_init;
   logic [31:0] window_init;
   logic [7:0]  prescale;
   logic        start;
   logic        stop;
   logic        kick;
   logic [31:0] curr_timer;
   logic        running;
   logic        timeout;
   logic        early_kick;

   typedef struct {
      string       tag;
      logic [31:0] timer;
      logic        run;
      logic        to;
      logic        ek;
   } exp_t;

   exp_t sbQueue[$];
   int   nAsserts;
   int   nFail;

   watchdog_window #(
      .TIMER_WIDTH(32),
      .PRESCALE_WIDTH(8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .timer_init (timer_init),
      .window_init(window_init),
      .prescale   (prescale),
      .start      (start),
      .stop       (stop),
      .kick       (kick),
      .curr_timer (curr_timer),
      .running    (running),
      .timeout    (timeout),
      .early_kick (early_kick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL sim_timeout: got no finish, want finish before 100000");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic applyStimulus(input logic s, input logic p, input logic k);
      start = s;
      stop  = p;
      kick  = k;
   endtask

   task automatic checkOutput();
      exp_t e;
      e = sbQueue.pop_front();
      nAsserts++;
      assert (curr_timer === e.timer) else begin
         nFail++;
         $error("[TB] FAIL %s curr_timer: got %0d, want %0d", e.tag, curr_timer, e.timer);
      end
      nAsserts++;
      assert (running === e.run) else begin
         nFail++;
         $error("[TB] FAIL %s running: got %b, want %b", e.tag, running, e.run);
      end
      nAsserts++;
      assert (timeout === e.to) else begin
         nFail++;
         $error("[TB] FAIL %s timeout: got %b, want %b", e.tag, timeout, e.to);
      end
      nAsserts++;
      assert (early_kick === e.ek) else begin
         nFail++;
         $error("[TB] FAIL %s early_kick: got %b, want %b", e.tag, early_kick, e.ek);
      end
   endtask

   // Push the expectation for the coming edge, advance one cycle, then score it.
   task automatic step(input string tag, input logic [31:0] t, input logic r,
                       input logic to, input logic ek);
      exp_t e;
      e.tag   = tag;
      e.timer = t;
      e.run   = r;
      e.to    = to;
      e.ek    = ek;
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput();
   endtask

   initial begin
      nAsserts    = 0;
      nFail       = 0;
      reset       = 1'b1;
      timer_init  = 32'd0;
      window_init = 32'd0;
      prescale    = 8'd0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      step("reset", 32'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      $display("[TB] basic countdown, prescale 0");
      timer_init = 32'd5;
      applyStimulus(1'b1, 1'b0, 1'b0);
      step("A_load", 32'd0, 1'b1, 1'b0, 1'b0);
      step("A_init", 32'd5, 1'b1, 1'b0, 1'b0);
      for (int t = 4; t >= 0; t--) begin
         step("A_count", t, 1'b1, 1'b0, 1'b0);
      end
      step("A_expire", 32'd0, 1'b0, 1'b1, 1'b0);

      applyStimulus(1'b1, 1'b0, 1'b0);
      step("T_start", 32'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      step("T_kick", 32'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      step("T_stop", 32'd0, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      step("T_reset", 32'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      $display("[TB] prescale 3, mid-period prescale glitch ignored");
      prescale   = 8'd3;
      timer_init = 32'd2;
      applyStimulus(1'b1, 1'b0, 1'b0);
      step("B_load", 32'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         prescale = (i == 2) ? 8'd0 : 8'd3;
         step("B_count", (i <= 4) ? 32'd2 : ((i <= 8) ? 32'd1 : 32'd0), 1'b1, 1'b0, 1'b0);
      end
      step("B_expire", 32'd0, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      step("B_reset", 32'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      prescale   = 8'd0;
      timer_init = 32'd10;
`ifdef WATCHDOG_WINDOW_EN
      $display("[TB] windowed kicks");
      window_init = 32'd4;
      applyStimulus(1'b1, 1'b0, 1'b0);
      step("C_load", 32'd0, 1'b1, 1'b0, 1'b0);
      for (int t = 10; t >= 7; t--) begin
         step("C_count", t, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      step("C_early", 32'd7, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      step("C_early_hold", 32'd7, 1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      step("C_reset", 32'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      step("C_load2", 32'd0, 1'b1, 1'b0, 1'b0);
      for (int t = 10; t >= 3; t--) begin
         step("C_count2", t, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      step("C_kick3", 32'd3, 1'b1, 1'b0, 1'b0);
      step("C_reload", 32'd10, 1'b1, 1'b0, 1'b0);
      step("C_after", 32'd9, 1'b1, 1'b0, 1'b0);
`else
      $display("[TB] non-windowed kicks");
      window_init = 32'd0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      step("C_load", 32'd0, 1'b1, 1'b0, 1'b0);
      for (int t = 10; t >= 7; t--) begin
         step("C_count", t, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      step("C_kick7", 32'd7, 1'b1, 1'b0, 1'b0);
      step("C_reload", 32'd10, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      step("C_kick10", 32'd10, 1'b1, 1'b0, 1'b0);
      step("C_reload2", 32'd10, 1'b1, 1'b0, 1'b0);
      step("C_after", 32'd9, 1'b1, 1'b0, 1'b0);
`endif

      $display("[TB] stop wins over start and kick");
      applyStimulus(1'b1, 1'b1, 1'b1);
      step("D_all", 32'd9, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      step("D_stop_idle", 32'd9, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      step("D_kick_idle", 32'd9, 1'b0, 1'b0, 1'b0);

      $display("[TB] zero timer_init expires on first tick");
      timer_init = 32'd0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      step("E_load", 32'd9, 1'b1, 1'b0, 1'b0);
      step("E_init", 32'd0, 1'b1, 1'b0, 1'b0);
      step("E_expire", 32'd0, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      step("E_reset", 32'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule

// File: doc/watchdog_window.md
WATCHDOG_WINDOW -- requirements
Module: watchdog_window

Interface
- REQ-001: Parameter TIMER_WIDTH, default 32: width of the countdown timer and its init/window values.
- REQ-002: Parameter PRESCALE_WIDTH, default 8: width of the prescaler compare value.
- REQ-003: Ports, clock and reset first:
  - clk  input  1  sole clock; all state updates on its rising edge.
  - reset  input  1  synchronous, active-high reset.
  - timer_init  input  TIMER_WIDTH  reload value for the countdown.
  - window_init  input  TIMER_WIDTH  open-window threshold; kick is legal only when the timer is at or below this value.
  - prescale  input  PRESCALE_WIDTH  a tick occurs every prescale+1 clk cycles.
  - start  input  1  single-cycle pulse; arms or restarts the watchdog.
  - stop  input  1  single-cycle pulse; disarms the watchdog.
  - kick  input  1  single-cycle pulse; services the watchdog.
  - curr_timer  output  TIMER_WIDTH  current timer value.
  - running  output  1  high in LOAD and COUNT.
  - timeout  output  1  sticky expiry flag.
  - early_kick  output  1  sticky flag: the timeout was caused by a kick outside the window.

Function
- REQ-004: FSM states are IDLE, LOAD, COUNT and TIMEOUT.
- REQ-005: IDLE + start: running=1 on the next cycle; go to LOAD. kick and stop are ignored in IDLE.
- REQ-006: LOAD lasts exactly one cycle.
  - Timer <= timer_init; prescaler count <= 0.
  - Go to COUNT.
- REQ-007: In COUNT, the prescaler counts 0..prescale and wraps to 0. A tick is asserted in the cycle the count equals prescale. prescale=0 gives a tick every cycle.
- REQ-008: COUNT, tick with timer != 0: timer decrements by 1. No tick: timer holds.
- REQ-009: COUNT, tick with timer == 0: go to TIMEOUT. The timer stays 0 and never wraps.
- REQ-010: COUNT priority per cycle is stop > start > kick > tick/expiry.
  - stop: go to IDLE, running=0 next cycle, timer holds its value.
  - start or legal kick: go to LOAD. No decrement that cycle.
- REQ-011: A kick is legal when curr_timer <= window_init. Illegal kick (windowed build only): go to TIMEOUT; early_kick=1 and timeout=1 on the next cycle.
- REQ-012: In TIMEOUT:
  - timeout=1, running=0.
  - start, stop and kick are ignored.
  - Only reset exits.
- REQ-013: Timing of the expiry path: timeout rises exactly one cycle after the expiring tick. Latency from start to the first decrement is therefore 2 + prescale cycles.
- REQ-014: timer_init, window_init and prescale are sampled only in LOAD and on every tick. Changes at other times have no effect.
- REQ-015: timer_init=0: the first tick after LOAD causes timeout.

Reset
- REQ-016: reset forces, on the next rising edge:
  - state=IDLE
  - curr_timer=0, prescaler count=0
  - running=0, timeout=0, early_kick=0
- REQ-017: reset takes priority over all inputs in every state, including mid-COUNT and TIMEOUT.

Configuration
- REQ-018: Macro WATCHDOG_WINDOW_EN controls windowing.
  - Defined: REQ-011 applies.
  - Undefined: every kick in COUNT is legal, window_init is unused, and early_kick is tied to 0.

Structure
- REQ-019: Shared package watchdog_pkg holds the FSM state typedef and encodings: IDLE=2'h0, LOAD=2'h1, COUNT=2'h2, TIMEOUT=2'h3.
- REQ-020: Sub-module watchdog_prescaler, parameterised by PRESCALE_WIDTH:
  - Inputs: clk, reset, clear, enable, prescale.
  - Output: tick.
  - The FSM drives clear in LOAD and enable in COUNT.

Verification
- REQ-021: prescale=0, timer_init=5, start pulse:
  - running=1 one cycle after start.
  - curr_timer reaches 5 on the cycle after that, then 4,3,2,1,0.
  - timeout=1 on the cycle after the tick taken at 0; running=0.
- REQ-022: prescale=3, timer_init=2: curr_timer decrements every 4 cycles; timeout is asserted 13 cycles after the start pulse.
- REQ-023: Windowed build, timer_init=10, window_init=4, prescale=0:
  - kick at curr_timer=7: timeout=1 and early_kick=1 on the next cycle.
  - kick at curr_timer=3: timer reloads to 10; no timeout.
- REQ-024: Simultaneous stop, start and kick in COUNT: the watchdog goes to IDLE and running=0. A later stop in IDLE is ignored.
- REQ-025: In TIMEOUT, pulse start, kick and stop: the flags hold. Assert reset for 1 cycle: all outputs are 0 and the state is IDLE.
- REQ-026: Non-windowed build (WATCHDOG_WINDOW_EN undefined), window_init=0: a kick at any timer value reloads the timer, and early_kick stays 0.
